id_ex_operand_stage: RTL and testbench

- ID/EX pipeline stage of the 5-stage RV32I core.
- Consumes the 2-bit operand-forward selects produced by the forwarding logic and muxes the regfile, EX, MEM and WB values into rs1/rs2 operands.
- Detects load-use hazards against its own registered (EX-stage) instruction, inserts bubbles and stalls IF/ID.
- Holds its contents under a downstream ready handshake.

---
 rtl/pipeline_pkg.sv | 13 +
 rtl/operand_fwd_mux.sv | 28 ++
 rtl/id_ex_operand_stage.sv | 148 ++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32I pipeline: forward-select encodings and
// default datapath/register-index widths.
package pipeline_pkg;

  localparam int XLEN_DEFAULT   = 32;
  localparam int REG_AW_DEFAULT = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_EX  = 2'b11;

endpackage : pipeline_pkg

// File: rtl/operand_fwd_mux.sv
// 4:1 operand forwarding mux: picks the regfile value or one of the
// EX/MEM/WB bypass sources according to the forward select.
module operand_fwd_mux
  import pipeline_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] rf_data,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] mem_data,
  input  logic [XLEN-1:0] ex_data,
  output logic [XLEN-1:0] out_data
);

  // Select the operand source; unknown encodings fall back to the regfile.
  always_comb begin
    out_data = rf_data;
    case (sel)
      FWD_EX:  out_data = ex_data;
      FWD_MEM: out_data = mem_data;
      FWD_WB:  out_data = wb_data;
      FWD_RF:  out_data = rf_data;
      default: out_data = rf_data;
    endcase
  end

endmodule : operand_fwd_mux

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline stage: forwards operands, detects load-use hazards against
// the instruction currently held in EX, inserts a single bubble per hazard
// and holds its contents while EX is not ready.
// Optional macro ID_EX_STATS_EN adds saturating stall/bubble counters.
module id_ex_operand_stage
  import pipeline_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   rf_rs1_data,
  input  logic [XLEN-1:0]   rf_rs2_data,
  input  logic [1:0]        forward_1,
  input  logic [1:0]        forward_2,
  input  logic [XLEN-1:0]   ex_fwd_data,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic [XLEN-1:0]   wb_fwd_data,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_pc
`ifdef ID_EX_STATS_EN
  ,
  output logic [31:0]       stat_stall_cycles,
  output logic [31:0]       stat_bubbles
`endif
);

  logic [XLEN-1:0] rs1_fwd_s;
  logic [XLEN-1:0] rs2_fwd_s;
  logic            load_use_s;
  logic            bubble_s;

  operand_fwd_mux #(.XLEN(XLEN)) u_rs1_mux (
    .sel      (forward_1),
    .rf_data  (rf_rs1_data),
    .wb_data  (wb_fwd_data),
    .mem_data (mem_fwd_data),
    .ex_data  (ex_fwd_data),
    .out_data (rs1_fwd_s)
  );

  operand_fwd_mux #(.XLEN(XLEN)) u_rs2_mux (
    .sel      (forward_2),
    .rf_data  (rf_rs2_data),
    .wb_data  (wb_fwd_data),
    .mem_data (mem_fwd_data),
    .ex_data  (ex_fwd_data),
    .out_data (rs2_fwd_s)
  );

  // Load-use detection against the EX-stage load, and the resulting stall.
  // x0 destinations never create a hazard; a flush cancels the stall.
  always_comb begin
    load_use_s = id_valid & ex_valid & ex_mem_read &
                 (ex_rd != {REG_AW{1'b0}}) &
                 ((id_use_rs1 & (id_rs1 == ex_rd)) |
                  (id_use_rs2 & (id_rs2 == ex_rd)));
    if (flush) begin
      id_stall = 1'b0;
    end else begin
      id_stall = id_valid & (load_use_s | ~ex_ready);
    end
    bubble_s = load_use_s & ex_ready & ~flush;
  end

  // Pipeline register: reset > flush > hold > load-use bubble > capture.
  always_ff @(posedge clk) begin
    if (reset || flush || (ex_ready && load_use_s)) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_rd        <= {REG_AW{1'b0}};
      ex_rs1_val   <= {XLEN{1'b0}};
      ex_rs2_val   <= {XLEN{1'b0}};
      ex_imm       <= {XLEN{1'b0}};
      ex_pc        <= {XLEN{1'b0}};
    end else if (!ex_ready) begin
      ex_valid     <= ex_valid;
      ex_reg_write <= ex_reg_write;
      ex_mem_read  <= ex_mem_read;
      ex_mem_write <= ex_mem_write;
      ex_rd        <= ex_rd;
      ex_rs1_val   <= ex_rs1_val;
      ex_rs2_val   <= ex_rs2_val;
      ex_imm       <= ex_imm;
      ex_pc        <= ex_pc;
    end else begin
      ex_valid     <= id_valid;
      ex_reg_write <= id_valid & id_reg_write;
      ex_mem_read  <= id_valid & id_mem_read;
      ex_mem_write <= id_valid & id_mem_write;
      ex_rd        <= id_rd;
      ex_rs1_val   <= rs1_fwd_s;
      ex_rs2_val   <= rs2_fwd_s;
      ex_imm       <= id_imm;
      ex_pc        <= id_pc;
    end
  end

`ifdef ID_EX_STATS_EN
  // Saturating counters for stall cycles and inserted load-use bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stall_cycles <= 32'd0;
      stat_bubbles      <= 32'd0;
    end else begin
      if (id_stall && (stat_stall_cycles != 32'hFFFF_FFFF)) begin
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end else begin
        stat_stall_cycles <= stat_stall_cycles;
      end
      if (bubble_s && (stat_bubbles != 32'hFFFF_FFFF)) begin
        stat_bubbles <= stat_bubbles + 32'd1;
      end else begin
        stat_bubbles <= stat_bubbles;
      end
    end
  end
`else
  // Bubble indication only feeds the optional counters.
  logic unused_bubble_s;
  assign unused_bubble_s = bubble_s;
`endif

endmodule : id_ex_operand_stage

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the stage.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic [31:0] id_imm, id_pc, rf_rs1_data, rf_rs2_data;
  logic [1:0]  forward_1, forward_2;
  logic [31:0] ex_fwd_data, mem_fwd_data, wb_fwd_data;
  logic        ex_ready, flush;
  logic        id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd;
  logic [31:0] ex_rs1_val, ex_rs2_val, ex_imm, ex_pc;
`ifdef ID_EX_STATS_EN
  logic [31:0] stat_stall_cycles, stat_bubbles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the EX stage should hold.
  logic        m_valid, m_rw, m_mr, m_mw;
  logic [4:0]  m_rd;
  logic [31:0] m_rs1, m_rs2, m_imm, m_pc;
  logic [31:0] m_stalls, m_bubbles;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_imm(id_imm), .id_pc(id_pc),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .forward_1(forward_1), .forward_2(forward_2),
    .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .ex_ready(ex_ready), .flush(flush), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_pc(ex_pc)
`ifdef ID_EX_STATS_EN
    , .stat_stall_cycles(stat_stall_cycles), .stat_bubbles(stat_bubbles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Operand chosen by a forward select, looked up from a source table.
  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
    logic [31:0] src [4];
    src[0] = rf; src[1] = wb_fwd_data; src[2] = mem_fwd_data; src[3] = ex_fwd_data;
    return src[sel];
  endfunction

  function automatic logic hazard();
    if (!(id_valid && m_valid && m_mr) || m_rd == 5'd0) return 1'b0;
    return (id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd);
  endfunction

  task automatic clear_model();
    m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_rd = 5'd0;
    m_rs1 = 32'd0; m_rs2 = 32'd0; m_imm = 32'd0; m_pc = 32'd0;
  endtask

  // One cycle: inputs are already driven (at negedge). Check the stall,
  // advance the model across the edge, then check the registered outputs.
  task automatic step();
    logic lu, stall_exp;
    logic [31:0] n_rs1, n_rs2;
    #1;
    lu = hazard();
    stall_exp = !flush && id_valid && (lu || !ex_ready);
    check("id_stall", {31'd0, id_stall}, {31'd0, stall_exp});
    n_rs1 = pick(forward_1, rf_rs1_data);
    n_rs2 = pick(forward_2, rf_rs2_data);
    @(posedge clk);
    if (reset) begin
      clear_model(); m_stalls = 32'd0; m_bubbles = 32'd0;
    end else begin
      if (stall_exp && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 32'd1;
      if (flush) clear_model();
      else if (!ex_ready) begin end
      else if (lu) begin
        clear_model();
        if (m_bubbles != 32'hFFFF_FFFF) m_bubbles = m_bubbles + 32'd1;
      end else begin
        m_valid = id_valid;
        m_rw = id_valid && id_reg_write;
        m_mr = id_valid && id_mem_read;
        m_mw = id_valid && id_mem_write;
        m_rd = id_rd; m_rs1 = n_rs1; m_rs2 = n_rs2; m_imm = id_imm; m_pc = id_pc;
      end
    end
    #1;
    check("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    check("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m_rw});
    check("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m_mr});
    check("ex_mem_write", {31'd0, ex_mem_write}, {31'd0, m_mw});
    check("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
    check("ex_rs1_val", ex_rs1_val, m_rs1);
    check("ex_rs2_val", ex_rs2_val, m_rs2);
    check("ex_imm", ex_imm, m_imm);
    check("ex_pc", ex_pc, m_pc);
`ifdef ID_EX_STATS_EN
    check("stat_stall_cycles", stat_stall_cycles, m_stalls);
    check("stat_bubbles", stat_bubbles, m_bubbles);
`endif
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    id_imm = 32'd0; id_pc = 32'd0; rf_rs1_data = 32'd0; rf_rs2_data = 32'd0;
    forward_1 = 2'b00; forward_2 = 2'b00;
    ex_fwd_data = 32'd0; mem_fwd_data = 32'd0; wb_fwd_data = 32'd0;
  endtask

  task automatic instr(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic mr);
    id_valid = 1'b1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    id_reg_write = 1'b1; id_mem_read = mr; id_mem_write = 1'b0;
    id_imm = 32'h0000_0040; id_pc = id_pc + 32'd4;
  endtask

  initial begin
    clear_model(); m_stalls = 32'd0; m_bubbles = 32'd0;
    idle();
    @(negedge clk);
    reset = 1'b1; step(); step();
    reset = 1'b0;

    // Plain capture from the regfile.
    instr(5'd3, 5'd1, 5'd2, 1'b0); rf_rs1_data = 32'h11; rf_rs2_data = 32'h22;
    step();
    check("plain_rs1", ex_rs1_val, 32'h11);
    check("plain_rs2", ex_rs2_val, 32'h22);

    // Forward priority: EX on rs1, WB on rs2.
    forward_1 = 2'b11; ex_fwd_data = 32'hAAAA;
    forward_2 = 2'b01; wb_fwd_data = 32'hCCCC; mem_fwd_data = 32'hBBBB;
    step();
    check("fwd_rs1", ex_rs1_val, 32'hAAAA);
    check("fwd_rs2", ex_rs2_val, 32'hCCCC);
    forward_1 = 2'b00; forward_2 = 2'b00;

    // Load-use: lw x5, then add x6,x5,x1 -> one bubble, then MEM forward.
    instr(5'd5, 5'd2, 5'd0, 1'b1); step();
    instr(5'd6, 5'd5, 5'd1, 1'b0); step();
    check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    forward_1 = 2'b10; mem_fwd_data = 32'h1234; step();
    check("lu_fwd_rs1", ex_rs1_val, 32'h1234);
    check("lu_after_valid", {31'd0, ex_valid}, 32'd1);
    forward_1 = 2'b00;

    // Load to x0 never stalls.
    instr(5'd0, 5'd2, 5'd3, 1'b1); step();
    instr(5'd7, 5'd0, 5'd4, 1'b0); id_use_rs2 = 1'b0; step();
    check("x0_no_bubble", {31'd0, ex_valid}, 32'd1);

    // Hold for three cycles, then flush while still held.
    instr(5'd8, 5'd1, 5'd2, 1'b0); rf_rs1_data = 32'h55; step();
    ex_ready = 1'b0; instr(5'd9, 5'd3, 5'd4, 1'b0); rf_rs1_data = 32'h66;
    for (int i = 0; i < 3; i++) step();
    check("hold_rs1", ex_rs1_val, 32'h55);
    flush = 1'b1; step();
    check("flush_valid", {31'd0, ex_valid}, 32'd0);
    flush = 1'b0; ex_ready = 1'b1;

    // Reset in the middle of a load-use.
    instr(5'd5, 5'd2, 5'd0, 1'b1); step();
    instr(5'd6, 5'd5, 5'd1, 1'b0); reset = 1'b1; step();
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    reset = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 9) == 0);
      ex_ready = ($urandom_range(0, 4) != 0);
      id_valid = ($urandom_range(0, 4) != 0);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 9) < 4);
      id_mem_write = 1'($urandom);
      id_imm = $urandom; id_pc = $urandom;
      rf_rs1_data = $urandom; rf_rs2_data = $urandom;
      forward_1 = 2'($urandom); forward_2 = 2'($urandom);
      ex_fwd_data = $urandom; mem_fwd_data = $urandom; wb_fwd_data = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_id_ex_operand_stage
